latch_file: RTL and testbench



---
 rtl/latch_file.sv | 108 ++++++++++
 tb/tb_latch_file.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/latch_file.sv
`default_nettype none
// ============================================================================
// Module   : latch_file
// Brief    : DEPTH-entry storage with one write port, two independent read
//            ports, per-entry valid bits, bulk clear, optional bypass and
//            optional registered read.
// Revision : 1.0
// ============================================================================
module latch_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int READ_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata0,
    output logic [WIDTH-1:0]  rdata1,
    output logic              rvalid0,
    output logic              rvalid1
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem     [DEPTH];
    logic             r_vld     [DEPTH];
    logic [WIDTH-1:0] w_mem_nxt [DEPTH];
    logic             w_vld_nxt [DEPTH];
    logic             w_wr_ok;
    logic [WIDTH:0]   w_rd0;
    logic [WIDTH:0]   w_rd1;

    assign w_wr_ok = write_en && ({1'b0, waddr} < c_DEPTH);

    // Post-edge contents ignoring reset; a write wins over clear for its entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_mem_nxt[i] = clear ? '0 : r_mem[i];
            w_vld_nxt[i] = clear ? 1'b0 : r_vld[i];
        end
        if (w_wr_ok) begin
            w_mem_nxt[waddr] = wdata;
            w_vld_nxt[waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset) begin
                r_mem[i] <= '0;
                r_vld[i] <= 1'b0;
            end else begin
                r_mem[i] <= w_mem_nxt[i];
                r_vld[i] <= w_vld_nxt[i];
            end
        end
    end

    // Bypass view is exactly the post-edge contents, so both read modes share it.
    function automatic logic [WIDTH:0] f_read(input logic [ADDR_W-1:0] a);
        logic [WIDTH:0] v;
        v = '0;
        if ({1'b0, a} < c_DEPTH) begin
            if (BYPASS != 0) v = {w_vld_nxt[a], w_mem_nxt[a]};
            else             v = {r_vld[a], r_mem[a]};
        end
        return v;
    endfunction

    always_comb begin
        w_rd0 = f_read(raddr0);
        w_rd1 = f_read(raddr1);
    end

    if (READ_REG != 0) begin : g_reg_read
        logic [WIDTH:0] r_out0;
        logic [WIDTH:0] r_out1;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_out0 <= '0;
                r_out1 <= '0;
            end else begin
                r_out0 <= w_rd0;
                r_out1 <= w_rd1;
            end
        end

        assign rdata0  = r_out0[WIDTH-1:0];
        assign rvalid0 = r_out0[WIDTH];
        assign rdata1  = r_out1[WIDTH-1:0];
        assign rvalid1 = r_out1[WIDTH];
    end else begin : g_comb_read
        assign rdata0  = w_rd0[WIDTH-1:0];
        assign rvalid0 = w_rd0[WIDTH];
        assign rdata1  = w_rd1[WIDTH-1:0];
        assign rvalid1 = w_rd1[WIDTH];
    end

endmodule
`default_nettype wire

// File: tb/tb_latch_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_latch_file
// Brief    : Randomised scoreboard bench for latch_file over five configurations.
// Revision : 1.0
// ============================================================================
module tb_latch_file;

    localparam int c_N = 5;
    // Per-instance configuration: depth, registered read, bypass.
    localparam int c_DEP [c_N] = '{6, 6, 6, 6, 8};
    localparam int c_RR  [c_N] = '{0, 0, 1, 1, 0};
    localparam int c_BYP [c_N] = '{1, 0, 1, 0, 1};

    typedef struct {
        bit          chk;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        v0;
        logic        v1;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        write_en;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr0;
    logic [2:0]  raddr1;

    logic [31:0] rd0 [c_N];
    logic [31:0] rd1 [c_N];
    logic        rv0 [c_N];
    logic        rv1 [c_N];

    exp_t        q [c_N][$];
    logic [31:0] m_mem [c_N][8];
    bit          m_vld [c_N][8];

    int total = 0;
    int bad   = 0;

    latch_file #(.WIDTH(32), .DEPTH(6), .READ_REG(0), .BYPASS(1)) u_d0 (
        .clk(clk), .reset(reset), .clear(clear), .write_en(write_en), .waddr(waddr),
        .wdata(wdata), .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0[0]),
        .rdata1(rd1[0]), .rvalid0(rv0[0]), .rvalid1(rv1[0]));
    latch_file #(.WIDTH(32), .DEPTH(6), .READ_REG(0), .BYPASS(0)) u_d1 (
        .clk(clk), .reset(reset), .clear(clear), .write_en(write_en), .waddr(waddr),
        .wdata(wdata), .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0[1]),
        .rdata1(rd1[1]), .rvalid0(rv0[1]), .rvalid1(rv1[1]));
    latch_file #(.WIDTH(32), .DEPTH(6), .READ_REG(1), .BYPASS(1)) u_d2 (
        .clk(clk), .reset(reset), .clear(clear), .write_en(write_en), .waddr(waddr),
        .wdata(wdata), .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0[2]),
        .rdata1(rd1[2]), .rvalid0(rv0[2]), .rvalid1(rv1[2]));
    latch_file #(.WIDTH(32), .DEPTH(6), .READ_REG(1), .BYPASS(0)) u_d3 (
        .clk(clk), .reset(reset), .clear(clear), .write_en(write_en), .waddr(waddr),
        .wdata(wdata), .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0[3]),
        .rdata1(rd1[3]), .rvalid0(rv0[3]), .rvalid1(rv1[3]));
    latch_file u_d4 (
        .clk(clk), .reset(reset), .clear(clear), .write_en(write_en), .waddr(waddr),
        .wdata(wdata), .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0[4]),
        .rdata1(rd1[4]), .rvalid0(rv0[4]), .rvalid1(rv1[4]));

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic compare(input int k, input exp_t e);
        total++;
        if (rd0[k] !== e.d0 || rv0[k] !== e.v0 || rd1[k] !== e.d1 || rv1[k] !== e.v1) begin
            bad++;
            $display("FAIL read cfg%0d @%0t: got p0=%h/%b p1=%h/%b want p0=%h/%b p1=%h/%b",
                     k, $time, rd0[k], rv0[k], rd1[k], rv1[k], e.d0, e.v0, e.d1, e.v1);
        end
    endtask

    // Combinational-read instances are sampled mid-cycle, registered ones just after the edge.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < c_N; k++) begin
            if (c_RR[k] == 0 && q[k].size() > 0) begin
                e = q[k].pop_front();
                if (e.chk) compare(k, e);
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        for (int k = 0; k < c_N; k++) begin
            if (c_RR[k] == 1 && q[k].size() > 0) begin
                e = q[k].pop_front();
                if (e.chk) compare(k, e);
            end
        end
    end

    // Contents of entry a as stored now (pre-edge), or after this cycle's edge.
    function automatic logic [32:0] pre_rd(input int k, input int a);
        if (a >= c_DEP[k]) return 33'd0;
        return {m_vld[k][a], m_mem[k][a]};
    endfunction

    function automatic logic [32:0] comb_rd(input int k, input int a, input bit clr,
                                            input bit we, input int wa, input logic [31:0] wd);
        if (a >= c_DEP[k]) return 33'd0;
        if (c_BYP[k] == 1 && we && wa == a && wa < c_DEP[k]) return {1'b1, wd};
        if (c_BYP[k] == 1 && clr) return 33'd0;
        return pre_rd(k, a);
    endfunction

    function automatic logic [32:0] post_rd(input int k, input int a, input bit clr,
                                            input bit we, input int wa, input logic [31:0] wd);
        if (a >= c_DEP[k]) return 33'd0;
        if (we && wa == a) return {1'b1, wd};
        if (clr) return 33'd0;
        return pre_rd(k, a);
    endfunction

    // Apply one cycle of inputs, queue the expected outputs, advance the model.
    task automatic step(input bit rst_n, input bit clr, input bit we, input int wa,
                        input logic [31:0] wd, input int a0, input int a1);
        exp_t e;
        logic [32:0] r0, r1;
        reset = rst_n; clear = clr; write_en = we;
        waddr = 3'(wa); wdata = wd; raddr0 = 3'(a0); raddr1 = 3'(a1);
        for (int k = 0; k < c_N; k++) begin
            if (c_RR[k] == 0) begin
                r0 = comb_rd(k, a0, clr, we, wa, wd);
                r1 = comb_rd(k, a1, clr, we, wa, wd);
                e.chk = rst_n;
            end else begin
                if (!rst_n) begin
                    r0 = '0; r1 = '0;
                end else if (c_BYP[k] == 1) begin
                    r0 = post_rd(k, a0, clr, we, wa, wd);
                    r1 = post_rd(k, a1, clr, we, wa, wd);
                end else begin
                    r0 = pre_rd(k, a0);
                    r1 = pre_rd(k, a1);
                end
                e.chk = 1'b1;
            end
            e.d0 = r0[31:0]; e.v0 = r0[32];
            e.d1 = r1[31:0]; e.v1 = r1[32];
            q[k].push_back(e);
        end
        for (int k = 0; k < c_N; k++) begin
            for (int i = 0; i < 8; i++) begin
                if (!rst_n || clr) begin
                    m_mem[k][i] = '0;
                    m_vld[k][i] = 1'b0;
                end
            end
            if (rst_n && we && wa < c_DEP[k]) begin
                m_mem[k][wa] = wd;
                m_vld[k][wa] = 1'b1;
            end
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int k = 0; k < c_N; k++)
            for (int i = 0; i < 8; i++) begin
                m_mem[k][i] = '0;
                m_vld[k][i] = 1'b0;
            end

        step(0, 0, 0, 0, 0, 0, 7);
        step(0, 0, 0, 0, 0, 0, 7);
        step(1, 0, 0, 0, 0, 0, 7);
        step(1, 0, 1, 3, 32'hDEADBEEF, 0, 7);
        step(1, 0, 1, 5, 32'h12345678, 3, 7);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 3, 5);
        step(1, 0, 1, 2, 32'hA5, 2, 3);
        step(1, 0, 0, 0, 0, 2, 3);
        step(1, 0, 1, 1, 32'h11, 1, 4);
        step(1, 0, 1, 4, 32'h44, 1, 4);
        step(1, 1, 1, 4, 32'h77, 1, 4);
        step(1, 0, 0, 0, 0, 1, 4);
        step(1, 0, 1, 7, 32'hFF, 6, 7);
        step(1, 0, 1, 6, 32'hEE, 6, 7);
        step(1, 0, 0, 0, 0, 6, 7);
        step(1, 0, 1, 0, 32'h33, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 32'h99, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)), $urandom,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
        step(1, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #3;

        for (int k = 0; k < c_N; k++) begin
            total++;
            if (q[k].size() != 0) begin
                bad++;
                $display("FAIL drain cfg%0d: got %0d pending want 0", k, q[k].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
